// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin ping scheduler for NCH ultrasonic rangers, one Trig at a time.
// Optional macro ULTRASONIC_ECHO_SYNC_EN adds a 2-flop synchronizer on every Echo bit.
module ultrasonic_scheduler #(
    parameter int NCH       = 4,
    parameter int TTRIG     = 500,
    parameter int TWAIT     = 1000000,
    parameter int TGAP      = 5000000,
    parameter int MAX_COUNT = 100000,
    parameter int CW        = $clog2(NCH)
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Enable,
    input  logic [NCH-1:0] ChMask,
    input  logic [NCH-1:0] Echo,
    output logic [NCH-1:0] Trig,
    output logic           Busy,
    output logic           DistValid,
    output logic [CW-1:0]  DistCh,
    output logic [31:0]    DistData,
    output logic           DistTimeout,
    output logic           DistOverflow
);

    typedef enum logic [1:0] {
        S_GAP  = 2'd0,
        S_TRIG = 2'd1,
        S_WAIT = 2'd2,
        S_MEAS = 2'd3
    } state_t;

    localparam logic [31:0] GAP_LOAD  = 32'(TGAP - 1);
    localparam logic [31:0] TRIG_LOAD = 32'(TTRIG - 1);
    localparam logic [31:0] WAIT_LOAD = 32'(TWAIT - 1);
    localparam logic [31:0] MAX_VAL   = 32'(MAX_COUNT);
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t        state, state_nxt;
    logic [31:0]   count, count_nxt;
    logic [CW-1:0] cur, cur_nxt;
    logic [CW-1:0] sel, cand;
    logic          sel_found;
    logic [NCH-1:0] echo_use;
    logic          echo_cur;
    logic          res;
    logic [31:0]   res_data;
    logic          res_to;
    logic          res_ovf;

`ifdef ULTRASONIC_ECHO_SYNC_EN
    logic [NCH-1:0] echo_meta;
    logic [NCH-1:0] echo_sync;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= Echo;
            echo_sync <= echo_meta;
        end
    end

    assign echo_use = echo_sync;
`else
    assign echo_use = Echo;
`endif

    assign echo_cur = echo_use[cur];

    // Round-robin search starting just after cur and ending at cur itself.
    always_comb begin
        sel       = cur;
        sel_found = 1'b0;
        cand      = cur;
        for (int i = 0; i < NCH; i++) begin
            cand = (cand == LAST_CH) ? '0 : cand + CW'(1);
            if (!sel_found && ChMask[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        cur_nxt   = cur;
        res       = 1'b0;
        res_data  = '0;
        res_to    = 1'b0;
        res_ovf   = 1'b0;
        unique case (state)
            S_GAP: begin
                if (count != '0) begin
                    count_nxt = count - 32'd1;
                end else if (Enable && sel_found) begin
                    cur_nxt   = sel;
                    state_nxt = S_TRIG;
                    count_nxt = TRIG_LOAD;
                end
            end
            S_TRIG: begin
                if (count == '0) begin
                    state_nxt = S_WAIT;
                    count_nxt = WAIT_LOAD;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            S_WAIT: begin
                if (echo_cur) begin
                    state_nxt = S_MEAS;
                    count_nxt = 32'd1;
                end else if (count == '0) begin
                    res       = 1'b1;
                    res_to    = 1'b1;
                    state_nxt = S_GAP;
                    count_nxt = GAP_LOAD;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            S_MEAS: begin
                if (!echo_cur) begin
                    res       = 1'b1;
                    res_data  = count;
                    state_nxt = S_GAP;
                    count_nxt = GAP_LOAD;
                end else if (count == MAX_VAL) begin
                    res       = 1'b1;
                    res_data  = MAX_VAL;
                    res_ovf   = 1'b1;
                    state_nxt = S_GAP;
                    count_nxt = GAP_LOAD;
                end else begin
                    count_nxt = count + 32'd1;
                end
            end
            default: begin
                state_nxt = S_GAP;
                count_nxt = GAP_LOAD;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_GAP;
            count <= GAP_LOAD;
            cur   <= LAST_CH;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            cur   <= cur_nxt;
        end
    end

    // Result fields hold their value until the next result.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            DistValid    <= 1'b0;
            DistCh       <= '0;
            DistData     <= '0;
            DistTimeout  <= 1'b0;
            DistOverflow <= 1'b0;
        end else begin
            DistValid <= res;
            if (res) begin
                DistCh       <= cur;
                DistData     <= res_data;
                DistTimeout  <= res_to;
                DistOverflow <= res_ovf;
            end
        end
    end

    // Decoded from state so an asynchronous reset drops Trig immediately.
    always_comb begin
        Trig = '0;
        if (state == S_TRIG) begin
            Trig[cur] = 1'b1;
        end
    end

    assign Busy = (state != S_GAP);

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Testbench for ultrasonic_scheduler: randomized pings checked cycle by cycle against a
// timeline model built from ping start, echo delay/width and the gap/trig/wait constants.
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;
    localparam int NCH       = 4;
    localparam int CW        = 2;
    localparam int TTRIG     = 5;
    localparam int TWAIT     = 100;
    localparam int TGAP      = 20;
    localparam int MAX_COUNT = 50;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic           Enable = 1'b0;
    logic [NCH-1:0] ChMask = '0;
    logic [NCH-1:0] Echo = '0;
    logic [NCH-1:0] Trig;
    logic           Busy;
    logic           DistValid;
    logic [CW-1:0]  DistCh;
    logic [31:0]    DistData;
    logic           DistTimeout;
    logic           DistOverflow;

    ultrasonic_scheduler #(
        .NCH(NCH), .TTRIG(TTRIG), .TWAIT(TWAIT), .TGAP(TGAP), .MAX_COUNT(MAX_COUNT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .ChMask(ChMask), .Echo(Echo),
        .Trig(Trig), .Busy(Busy), .DistValid(DistValid), .DistCh(DistCh),
        .DistData(DistData), .DistTimeout(DistTimeout), .DistOverflow(DistOverflow)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_m;
    int base;
    logic [CW-1:0] exp_ch;
    logic [31:0]   exp_data;
    logic          exp_to;
    logic          exp_ovf;
    int e_ch = -1;
    int e_lo = 0;
    int e_hi = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [NCH-1:0] onehot(input int ch);
        return NCH'(1) << ch;
    endfunction

    function automatic int next_ch(input int cur, input logic [NCH-1:0] mask);
        int r;
        r = cur;
        for (int i = NCH; i >= 1; i--)
            if (((mask >> ((cur + i) % NCH)) & NCH'(1)) != '0) r = (cur + i) % NCH;
        return r;
    endfunction

    task automatic tick();
        @(posedge Clock);
        cyc++;
        #1;
    endtask

    // Non-selected channels get random noise; the echo window drives its own channel.
    task automatic drive_echo(input int ping_ch);
        logic [NCH-1:0] v;
        v = NCH'($urandom);
        if (ping_ch >= 0) v &= ~onehot(ping_ch);
        if (e_ch >= 0) begin
            v &= ~onehot(e_ch);
            if (cyc >= e_lo && cyc < e_hi) v |= onehot(e_ch);
        end
        Echo = v;
    endtask

    task automatic check_outs(input logic [NCH-1:0] trig_exp, input logic busy_exp, input logic dv_exp);
        @(negedge Clock);
        check("trig", 32'(Trig), 32'(trig_exp));
        check("busy", 32'(Busy), 32'(busy_exp));
        check("dist_valid", 32'(DistValid), 32'(dv_exp));
        check("dist_ch", 32'(DistCh), 32'(exp_ch));
        check("dist_data", DistData, exp_data);
        check("dist_timeout", 32'(DistTimeout), 32'(exp_to));
        check("dist_overflow", 32'(DistOverflow), 32'(exp_ovf));
    endtask

    task automatic clear_expect();
        exp_ch = '0; exp_data = '0; exp_to = 1'b0; exp_ovf = 1'b0;
        cur_m = NCH - 1;
        e_ch = -1;
    endtask

    // Quiet period: selection happens at the first edge >= base+TGAP with Enable && |ChMask.
    task automatic gap(input logic en, input logic [NCH-1:0] mask, input int extra,
                       output bit started);
        int act;
        act = base + TGAP - 1 + extra;
        started = 1'b0;
        for (int n = 0; n < 2000 && !started; n++) begin
            tick();
            if (cyc >= act) begin
                Enable = en; ChMask = mask;
            end else if (cyc >= base + TGAP - 1) begin
                Enable = 1'b0; ChMask = NCH'($urandom);
            end else begin
                Enable = 1'($urandom_range(0, 1)); ChMask = NCH'($urandom);
            end
            drive_echo(-1);
            check_outs('0, 1'b0, 1'b0);
            if (cyc + 1 >= base + TGAP && Enable && ChMask != '0) started = 1'b1;
            else if (cyc >= act && !(en && mask != '0)) break;
        end
    endtask

    // kind: 0 fixed 3/10, 1 timeout, 2 overflow, 3 echo on last wait cycle,
    //       4 width exactly MAX_COUNT, 5 short random, 6 wide random
    task automatic ping(input int kind, input bit chaos);
        int ch, d, w, ts, tf, tr;
        logic [31:0] data;
        logic to, ovf;
        ts = cyc + 1;
        ch = next_ch(cur_m, ChMask);
        cur_m = ch;
        tf = ts + TTRIG;
        d = $urandom_range(0, 8);
        w = $urandom_range(1, 20);
        case (kind)
            0: begin d = 3; w = 10; end
            2: w = MAX_COUNT + 1 + $urandom_range(0, 8);
            3: d = TWAIT - 1;
            4: w = MAX_COUNT;
            6: begin d = $urandom_range(0, TWAIT - 1); w = $urandom_range(1, MAX_COUNT + 5); end
            default: ;
        endcase
        if (kind == 1) begin
            tr = tf + TWAIT; data = 0; to = 1'b1; ovf = 1'b0; e_ch = -1;
        end else begin
            e_ch = ch; e_lo = tf + d; e_hi = tf + d + w; to = 1'b0;
            if (w <= MAX_COUNT) begin
                tr = tf + d + w + 1; data = 32'(w); ovf = 1'b0;
            end else begin
                tr = tf + d + MAX_COUNT + 1; data = 32'(MAX_COUNT); ovf = 1'b1;
            end
        end
        for (int c = ts; c <= tr; c++) begin
            tick();
            if (chaos) begin
                Enable = 1'($urandom_range(0, 1)); ChMask = NCH'($urandom);
            end
            drive_echo(ch);
            if (c < tf) check_outs(onehot(ch), 1'b1, 1'b0);
            else if (c < tr) check_outs('0, 1'b1, 1'b0);
            else begin
                exp_ch = CW'(ch); exp_data = data; exp_to = to; exp_ovf = ovf;
                check_outs('0, 1'b0, 1'b1);
            end
        end
        base = tr;
    endtask

    task automatic run(input logic en, input logic [NCH-1:0] mask, input int extra,
                       input int kind, input bit chaos);
        bit started;
        gap(en, mask, extra, started);
        if (started) ping(kind, chaos);
    endtask

    task automatic reset_mid_trig(input int k);
        bit started;
        int ch;
        gap(1'b1, 4'b0010, 0, started);
        check("rst_ping_started", 32'(started), 32'd1);
        ch = next_ch(cur_m, ChMask);
        for (int c = 0; c < k; c++) begin
            tick(); drive_echo(ch); check_outs(onehot(ch), 1'b1, 1'b0);
        end
        tick();
        Reset = 1'b1;
        #1;
        check("trig_async_reset", 32'(Trig), 32'd0);
        check("busy_async_reset", 32'(Busy), 32'd0);
        clear_expect();
        repeat (2) begin
            tick(); drive_echo(-1); check_outs('0, 1'b0, 1'b0);
        end
        Reset = 1'b0;
        base = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_expect();
        repeat (3) begin
            tick(); check_outs('0, 1'b0, 1'b0);
        end
        Reset = 1'b0;
        base = cyc;

        repeat (5) run(1'b1, 4'b1111, 0, 0, 1'b0);
        repeat (6) run(1'b1, 4'b0101, 0, 5, 1'b0);
        run(1'b1, 4'b0100, 0, 1, 1'b0);
        run(1'b1, 4'b0100, 0, 0, 1'b0);
        run(1'b1, 4'b0001, 0, 2, 1'b0);
        run(1'b1, 4'b1111, 0, 0, 1'b0);
        run(1'b1, 4'b1111, 0, 3, 1'b0);
        run(1'b1, 4'b1111, 0, 4, 1'b0);
        reset_mid_trig(2);
        run(1'b1, 4'b1111, 0, 0, 1'b0);
        run(1'b1, 4'b1000, 0, 5, 1'b1);
        run(1'b0, 4'b1111, 15, 0, 1'b0);
        run(1'b1, 4'b0000, 5, 0, 1'b0);
        run(1'b1, 4'b1111, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run(1'($urandom_range(0, 3) != 0), NCH'($urandom), $urandom_range(0, 5),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
